conv1d_param: RTL
=================

Name: conv1d_param

Overview:
- Parametrised successor of the fixed 128/32 convolution top: y[k] = sum over j of x[k*STRIDE+j]*f[j], for k = 0..CONV_N-1.
- Signed stream inputs (valid/ready) for the data vector x and the filter f; signed stream output y.
- New behaviour over the fixed block:
  - generic sizes and widths;
  - output stride;
  - filter reuse across vectors;
  - optional ReLU;
  - last-output marker.
- Sits as the convolution engine between the input streamers and the result sink.

Parameters:
- DATA_N, 128, samples per input vector (≥ FILTER_N).
- FILTER_N, 32, filter taps (≥ 2).
- STRIDE, 1, output stride (≥ 1).
- W_X, 8, signed x sample width.
- W_F, 8, signed filter tap width.
- Derived (localparam): CONV_N = (DATA_N-FILTER_N)/STRIDE + 1 (floor).
- Derived (localparam): OUT_W = W_X + W_F + $clog2(FILTER_N), which gives 21 at defaults.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- s_valid_x  in  1  x sample valid.
- s_ready_x  out  1  x sample accepted when s_valid_x && s_ready_x.
- s_data_in_x  in  W_X  signed x sample.
- s_valid_f  in  1  filter tap valid.
- s_ready_f  out  1  filter tap accepted on handshake.
- s_data_in_f  in  W_F  signed filter tap.
- cfg_reuse_f  in  1  keep current filter for the next vector.
- cfg_relu  in  1  clamp negative results to 0.
- m_ready_y  in  1  sink ready.
- m_valid_y  out  1  output valid.
- m_data_out_y  out  OUT_W  signed result.
- m_last_y  out  1  high with y[CONV_N-1].

Behaviour:
- Reset (asserted): state LOAD, x/f counters 0, f_loaded=0, accumulator 0.
- Reset values: s_ready_x=0, s_ready_f=0, m_valid_y=0, m_last_y=0, m_data_out_y=0.
- Ready outputs rise the first cycle after reset deasserts.
- Reset mid-operation aborts everything; stored x/f contents are don't-care, f_loaded is cleared.
- State LOAD:
  - s_ready_x = (x_cnt < DATA_N).
  - s_ready_f = (f_cnt < FILTER_N) && !f_loaded.
  - x and f load concurrently and independently. Samples are written in arrival order into x_mem[0..DATA_N-1] and f_mem[0..FILTER_N-1].
  - Exit to COMPUTE the cycle after x_cnt==DATA_N and (f_cnt==FILTER_N or f_loaded). Set f_loaded=1 and k=0.
- State COMPUTE:
  - Memories are synchronous-read (1-cycle latency).
  - For tap j = 0..FILTER_N-1: read x_mem[k*STRIDE+j] and f_mem[j]. Accumulator is cleared with the first product, then accumulates.
  - Product is full-precision signed W_X+W_F. The accumulator is OUT_W wide and cannot overflow.
  - After the last product: if cfg_relu (sampled at COMPUTE entry for that output) and result < 0, result becomes 0.
  - The result is registered into m_data_out_y; go to OUTPUT.
  - m_valid_y rises exactly FILTER_N+2 cycles after COMPUTE entry.
- State OUTPUT:
  - m_valid_y=1. m_data_out_y and m_last_y (= k==CONV_N-1) are held stable until m_ready_y.
  - On handshake with k < CONV_N-1: k++, return to COMPUTE in the next cycle, m_valid_y=0.
  - On handshake with k == CONV_N-1: go to LOAD and clear x_cnt.
    - If cfg_reuse_f==1 in that cycle, f_loaded stays 1 (filter input idle, s_ready_f=0).
    - Otherwise clear f_cnt and f_loaded.
- s_ready_x and s_ready_f are 0 outside LOAD. Inputs offered there are stalled, not dropped.
- Backpressure: m_ready_y low holds OUTPUT indefinitely and no computation proceeds.
- Samples beyond the counts are not accepted; ready goes low the cycle after the final accept.
- Boundary cases:
  - STRIDE such that DATA_N-FILTER_N is not a multiple: the tail samples are unused.
  - FILTER_N==DATA_N: CONV_N=1.
- Throughput per output: FILTER_N+2 compute cycles plus ≥1 output cycle.

Decomposition:
- Package conv1d_pkg: a function for CONV_N and OUT_W, and an enum state_t {LOAD, COMPUTE, OUTPUT}.
- One natural sub-module, conv1d_mac: registered signed multiply-accumulate with clear, enable and ReLU. Memories and FSM stay in the top.

Test Plan:
- Defaults; x[i]=i-64, f[j]=1, sink always ready:
  - 97 outputs, y[0] = sum(-64..-33) = -1552, y[96] = sum(32..63) = 1520.
  - m_last_y only on the 97th output.
- x all -128, f all -128 (maximum positive product):
  - every y = 524288 (32*16384), which fits 21-bit signed.
- With cfg_relu=1, same as x=-128, f=+127:
  - every y = 0.
  - With cfg_relu=0: y = -520192.
- STRIDE=3, DATA_N=16, FILTER_N=4, x[i]=i, f=[1,0,0,0]:
  - CONV_N=5, y = 0,3,6,9,12.
- Vector 1 with f=[1,2] (DATA_N=4, FILTER_N=2), cfg_reuse_f=1 at the last handshake; vector 2 sends only x=[1,1,1,1]:
  - s_ready_f stays 0, y = 3,3,3.
- Random s_valid, m_ready gaps, and a reset pulse mid-COMPUTE:
  - Outputs are reset immediately.
  - A subsequent full reload produces golden-model results, with no lost or duplicated samples.

Source files
------------

// File: rtl/conv1d_pkg.sv
// Shared state type and size helpers for the parametrised 1-D convolution engine.
package conv1d_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  function automatic int convN(input int dataN, input int filterN, input int stride);
    return (dataN - filterN) / stride + 1;
  endfunction

  // Wide enough that FILTER_N full-precision products can never overflow.
  function automatic int outW(input int wX, input int wF, input int filterN);
    return wX + wF + $clog2(filterN);
  endfunction

endpackage

// File: rtl/conv1d_mac.sv
// Registered signed multiply-accumulate for one convolution output, with a
// first-product clear and an optional ReLU on the finished sum.
module conv1d_mac
  import conv1d_pkg::*;
#(
  parameter int W_X   = 8,
  parameter int W_F   = 8,
  parameter int OUT_W = 21
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_en,
  input  logic                    i_clear,
  input  logic                    i_relu,
  input  logic signed [W_X-1:0]   i_x,
  input  logic signed [W_F-1:0]   i_f,
  output logic signed [OUT_W-1:0] o_result
);

  logic signed [W_X+W_F-1:0] w_prod;
  logic signed [OUT_W-1:0]   w_prodExt;
  logic signed [OUT_W-1:0]   r_acc;

  assign w_prod    = i_x * i_f;
  assign w_prodExt = OUT_W'(w_prod);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= i_clear ? w_prodExt : r_acc + w_prodExt;
    end
  end

  assign o_result = (i_relu && r_acc[OUT_W-1]) ? '0 : r_acc;

endmodule

// File: rtl/conv1d_param.sv
// Parametrised 1-D convolution engine: loads x and f over valid/ready streams,
// then emits y[k] = sum_j x[k*STRIDE+j]*f[j] one result at a time.
module conv1d_param
  import conv1d_pkg::*;
#(
  parameter int  DATA_N   = 128,
  parameter int  FILTER_N = 32,
  parameter int  STRIDE   = 1,
  parameter int  W_X      = 8,
  parameter int  W_F      = 8,
  localparam int CONV_N   = convN(DATA_N, FILTER_N, STRIDE),
  localparam int OUT_W    = outW(W_X, W_F, FILTER_N)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_valid_x,
  output logic                    s_ready_x,
  input  logic signed [W_X-1:0]   s_data_in_x,
  input  logic                    s_valid_f,
  output logic                    s_ready_f,
  input  logic signed [W_F-1:0]   s_data_in_f,
  input  logic                    cfg_reuse_f,
  input  logic                    cfg_relu,
  input  logic                    m_ready_y,
  output logic                    m_valid_y,
  output logic signed [OUT_W-1:0] m_data_out_y,
  output logic                    m_last_y
);

  localparam int XA_W  = $clog2(DATA_N);
  localparam int FA_W  = $clog2(FILTER_N);
  localparam int XC_W  = $clog2(DATA_N + 1);
  localparam int FC_W  = $clog2(FILTER_N + 1);
  localparam int TAP_W = $clog2(FILTER_N + 2);
  localparam int K_W   = $clog2(CONV_N + 1);

  localparam logic [XC_W-1:0]  X_FULL   = XC_W'(DATA_N);
  localparam logic [FC_W-1:0]  F_FULL   = FC_W'(FILTER_N);
  localparam logic [TAP_W-1:0] TAP_RD   = TAP_W'(FILTER_N);
  localparam logic [TAP_W-1:0] TAP_DONE = TAP_W'(FILTER_N + 1);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(CONV_N - 1);
  localparam logic [XA_W-1:0]  X_STEP   = XA_W'(STRIDE);

  state_t r_state;
  state_t w_nextState;

  logic                    r_run;
  logic [XC_W-1:0]         r_xCnt;
  logic [FC_W-1:0]         r_fCnt;
  logic                    r_fLoaded;
  logic [K_W-1:0]          r_k;
  logic [XA_W-1:0]         r_base;
  logic [TAP_W-1:0]        r_tap;
  logic                    r_relu;
  logic                    r_rdValid;
  logic                    r_rdFirst;
  logic signed [W_X-1:0]   r_xRd;
  logic signed [W_F-1:0]   r_fRd;
  logic signed [OUT_W-1:0] r_dataOut;

  logic signed [W_X-1:0]   r_xMem [DATA_N];
  logic signed [W_F-1:0]   r_fMem [FILTER_N];

  logic                    w_xAccept;
  logic                    w_fAccept;
  logic                    w_loadDone;
  logic                    w_lastK;
  logic [XA_W-1:0]         w_xAddr;
  logic [FA_W-1:0]         w_fAddr;
  logic signed [OUT_W-1:0] w_macResult;

  assign w_xAccept  = s_valid_x && s_ready_x;
  assign w_fAccept  = s_valid_f && s_ready_f;
  assign w_loadDone = (r_xCnt == X_FULL) && ((r_fCnt == F_FULL) || r_fLoaded);
  assign w_lastK    = (r_k == K_LAST);
  assign w_xAddr    = r_base + XA_W'(r_tap);
  assign w_fAddr    = FA_W'(r_tap);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      LOAD: begin
        if (w_loadDone) w_nextState = COMPUTE;
      end
      COMPUTE: begin
        if (r_tap == TAP_DONE) w_nextState = OUTPUT;
      end
      OUTPUT: begin
        if (m_ready_y) w_nextState = w_lastK ? LOAD : COMPUTE;
      end
      default: w_nextState = LOAD;
    endcase
  end

  // r_run keeps both ready outputs low until the first clock after reset release.
  always_comb begin
    s_ready_x = 1'b0;
    s_ready_f = 1'b0;
    m_valid_y = 1'b0;
    m_last_y  = 1'b0;
    case (r_state)
      LOAD: begin
        s_ready_x = r_run && (r_xCnt < X_FULL);
        s_ready_f = r_run && (r_fCnt < F_FULL) && !r_fLoaded;
      end
      OUTPUT: begin
        m_valid_y = 1'b1;
        m_last_y  = w_lastK;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_run     <= 1'b0;
      r_xCnt    <= '0;
      r_fCnt    <= '0;
      r_fLoaded <= 1'b0;
      r_k       <= '0;
      r_base    <= '0;
      r_tap     <= '0;
      r_relu    <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_xAccept) r_xCnt <= r_xCnt + 1'b1;
      if (w_fAccept) r_fCnt <= r_fCnt + 1'b1;
      r_tap <= ((r_state == COMPUTE) && (r_tap != TAP_DONE)) ? r_tap + 1'b1 : '0;
      case (r_state)
        LOAD: begin
          if (w_loadDone) begin
            r_fLoaded <= 1'b1;
            r_k       <= '0;
            r_base    <= '0;
            r_relu    <= cfg_relu;
          end
        end
        OUTPUT: begin
          if (m_ready_y) begin
            if (w_lastK) begin
              r_xCnt <= '0;
              if (!cfg_reuse_f) begin
                r_fCnt    <= '0;
                r_fLoaded <= 1'b0;
              end
            end else begin
              r_k    <= r_k + 1'b1;
              r_base <= r_base + X_STEP;
              r_relu <= cfg_relu;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Sample storage is never reset; contents are only trusted after a full load.
  always_ff @(posedge clk) begin
    if (w_xAccept) r_xMem[XA_W'(r_xCnt)] <= s_data_in_x;
    if (w_fAccept) r_fMem[FA_W'(r_fCnt)] <= s_data_in_f;
    r_xRd <= r_xMem[w_xAddr];
    r_fRd <= r_fMem[w_fAddr];
  end

  // Reads issue on taps 0..FILTER_N-1; the MAC consumes them one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdValid <= 1'b0;
      r_rdFirst <= 1'b0;
      r_dataOut <= '0;
    end else begin
      r_rdValid <= (r_state == COMPUTE) && (r_tap < TAP_RD);
      r_rdFirst <= (r_state == COMPUTE) && (r_tap == '0);
      if ((r_state == COMPUTE) && (r_tap == TAP_DONE)) r_dataOut <= w_macResult;
    end
  end

  conv1d_mac #(
    .W_X   (W_X),
    .W_F   (W_F),
    .OUT_W (OUT_W)
  ) u_mac (
    .clk      (clk),
    .reset    (reset),
    .i_en     (r_rdValid),
    .i_clear  (r_rdFirst),
    .i_relu   (r_relu),
    .i_x      (r_xRd),
    .i_f      (r_fRd),
    .o_result (w_macResult)
  );

  assign m_data_out_y = r_dataOut;

endmodule
